sprite_anim: RTL and testbench



---
 rtl/sprite_anim.sv | 219 +++++++++++++++++++++
 tb/tb_sprite_anim.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim.sv
// sprite_anim: animated sprite hit-test with mirroring and post-hit blink.
// Latency: is_sprite is registered 1 Clk after DrawX/DrawY/Pos/flip_x.
// Backpressure: none; pixel-rate streaming, frame_clk paces the animation.
//
// Ports:
//   Clk, Reset (synchronous, active-high)
//   frame_clk        vsync-derived frame clock, rising edge sampled on Clk
//   DrawX, DrawY     current pixel coordinate
//   Pos_X, Pos_Y     sprite top-left coordinate
//   play             1 = animate, 0 = return to and hold frame 0
//   flip_x           mirror the sprite horizontally
//   hit              one-cycle pulse that starts/restarts blinking
//   is_sprite        registered pixel-opaque flag
//   frame_idx        current animation frame
//   blinking         blink counter nonzero
//   done             one-shot animation finished
//
// Optional feature: define SPRITE_SCALE2_EN to draw each bitmap pixel as a
// 2x2 block (footprint 2*SIZE x 2*SIZE).

module sprite_anim #(
  parameter int SIZE        = 16,
  parameter int FRAMES      = 4,
  parameter int FRAME_HOLD  = 8,
  parameter int BLINK_TICKS = 32,
  parameter int ONESHOT     = 0,
  parameter logic [0:FRAMES*SIZE-1][SIZE-1:0] SPRITE = '1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] Pos_X,
  input  logic [9:0] Pos_Y,
  input  logic       play,
  input  logic       flip_x,
  input  logic       hit,
  output logic       is_sprite,
  output logic [((FRAMES > 1) ? $clog2(FRAMES) : 1)-1:0] frame_idx,
  output logic       blinking,
  output logic       done
);

  localparam int FW   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HW   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int ROWS = FRAMES * SIZE;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef SPRITE_SCALE2_EN
  localparam int FOOT = 2 * SIZE;
`else
  localparam int FOOT = SIZE;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [HW-1:0]  r_hold_cnt;
  logic [FW-1:0]  r_frame_idx;
  logic           r_done;
  logic           r_frame_clk_d;
  logic [7:0]     r_blink_cnt;
  logic           r_blinking;
  logic           r_is_sprite;

  logic           w_tick;
  logic [7:0]     w_blink_nxt;
  logic           w_blank;
  logic [9:0]     w_dx;
  logic [9:0]     w_dy;
  logic [CW-1:0]  w_dx_src;
  logic [CW-1:0]  w_dy_src;
  logic           w_inside;
  logic [CW-1:0]  w_bit_pos;
  logic [RW-1:0]  w_row_idx;
  logic [SIZE-1:0] w_row;
  logic           w_bit;

  // One-cycle tick per rising edge of frame_clk.
  assign w_tick = frame_clk & ~r_frame_clk_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_clk_d <= 1'b0;
    end else begin
      r_frame_clk_d <= frame_clk;
    end
  end

  // Animation sequencer. play=0 in RUN wins over a coincident tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_hold_cnt  <= '0;
      r_frame_idx <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_hold_cnt  <= '0;
          r_frame_idx <= '0;
          r_done      <= 1'b0;
          if (play) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!play) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_frame_idx <= '0;
          end else if (w_tick) begin
            if (r_hold_cnt != HW'(FRAME_HOLD - 1)) begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
              r_hold_cnt <= '0;
              if (r_frame_idx == FW'(FRAMES - 1)) begin
                if (ONESHOT != 0) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_frame_idx <= '0;
                end
              end else begin
                r_frame_idx <= r_frame_idx + 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (!play) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_frame_idx <= '0;
            r_done      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_hold_cnt  <= '0;
          r_frame_idx <= '0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // Blink counter: a hit reloads even while blinking and beats a tick.
  always_comb begin
    w_blink_nxt = r_blink_cnt;
    if (hit) begin
      w_blink_nxt = 8'(BLINK_TICKS);
    end else if (w_tick && (r_blink_cnt != 8'd0)) begin
      w_blink_nxt = r_blink_cnt - 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_blink_cnt <= 8'd0;
      r_blinking  <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_nxt;
      r_blinking  <= (w_blink_nxt != 8'd0);
    end
  end

  // Counter bit 1 gives a 2-tick on / 2-tick off cadence.
  assign w_blank = r_blinking & r_blink_cnt[1];

  // Offsets wrap modulo 2^10; the >= compares reject the wrapped cases, so
  // a sprite near column 1023 never reappears at column 0.
  assign w_dx = DrawX - Pos_X;
  assign w_dy = DrawY - Pos_Y;

`ifdef SPRITE_SCALE2_EN
  assign w_dx_src = CW'(w_dx >> 1);
  assign w_dy_src = CW'(w_dy >> 1);
`else
  assign w_dx_src = CW'(w_dx);
  assign w_dy_src = CW'(w_dy);
`endif

  assign w_inside = (DrawX >= Pos_X) && (DrawY >= Pos_Y) &&
                    (w_dx < 10'(FOOT)) && (w_dy < 10'(FOOT));

  // Bit SIZE-1 is column 0; mirroring turns the bit position into dx itself.
  // Indices are forced to 0 outside the footprint to stay within the bitmap.
  always_comb begin
    w_bit_pos = '0;
    w_row_idx = '0;
    if (w_inside) begin
      w_bit_pos = flip_x ? w_dx_src : (CW'(SIZE - 1) - w_dx_src);
      w_row_idx = RW'(r_frame_idx) * RW'(SIZE) + RW'(w_dy_src);
    end
  end

  assign w_row = SPRITE[w_row_idx];
  assign w_bit = w_row[w_bit_pos];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_is_sprite <= 1'b0;
    end else begin
      r_is_sprite <= w_inside & w_bit & ~w_blank;
    end
  end

  assign is_sprite = r_is_sprite;
  assign frame_idx = r_frame_idx;
  assign blinking  = r_blinking;
  assign done      = r_done;

endmodule

// File: tb/tb_sprite_anim.sv
// Directed bench for sprite_anim: several instances with different
// parameters share one stimulus set; each task checks one feature.
`timescale 1ns/1ps

module tb_sprite_anim;

  int total = 0;
  int bad   = 0;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [9:0] DrawX, DrawY, Pos_X, Pos_Y;
  logic       play, flip_x, hit;

  always #5 Clk = ~Clk;

  function automatic logic [0:31][15:0] mk_pix();
    logic [0:31][15:0] b;
    b = '0;
    b[3] = 16'h8000;
    return b;
  endfunction

  function automatic logic [0:31][15:0] mk_sc();
    logic [0:31][15:0] b;
    b = '0;
    b[1] = 16'h4000;
    return b;
  endfunction

  // Bitmap test: SIZE=16, FRAMES=2
  logic       pix_is, pix_fi, pix_bl, pix_dn;
  sprite_anim #(.SIZE(16), .FRAMES(2), .SPRITE(mk_pix())) u_pix (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .Pos_X(Pos_X), .Pos_Y(Pos_Y),
    .play(play), .flip_x(flip_x), .hit(hit),
    .is_sprite(pix_is), .frame_idx(pix_fi), .blinking(pix_bl), .done(pix_dn));

  // Looping animation, all-ones bitmap
  logic       loop_is, loop_bl, loop_dn;
  logic [1:0] loop_fi;
  sprite_anim #(.SIZE(16), .FRAMES(4), .FRAME_HOLD(2)) u_loop (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .Pos_X(Pos_X), .Pos_Y(Pos_Y),
    .play(play), .flip_x(flip_x), .hit(hit),
    .is_sprite(loop_is), .frame_idx(loop_fi), .blinking(loop_bl), .done(loop_dn));

  // One-shot animation
  logic       one_is, one_bl, one_dn;
  logic [1:0] one_fi;
  sprite_anim #(.SIZE(16), .FRAMES(3), .FRAME_HOLD(1), .ONESHOT(1)) u_one (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .Pos_X(Pos_X), .Pos_Y(Pos_Y),
    .play(play), .flip_x(flip_x), .hit(hit),
    .is_sprite(one_is), .frame_idx(one_fi), .blinking(one_bl), .done(one_dn));

  // Blink
  logic       bl_is, bl_bl, bl_dn;
  logic [1:0] bl_fi;
  sprite_anim #(.SIZE(16), .FRAMES(4), .BLINK_TICKS(8)) u_blink (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .Pos_X(Pos_X), .Pos_Y(Pos_Y),
    .play(play), .flip_x(flip_x), .hit(hit),
    .is_sprite(bl_is), .frame_idx(bl_fi), .blinking(bl_bl), .done(bl_dn));

`ifdef SPRITE_SCALE2_EN
  logic       sc_is, sc_fi, sc_bl, sc_dn;
  sprite_anim #(.SIZE(16), .FRAMES(2), .SPRITE(mk_sc())) u_sc (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .Pos_X(Pos_X), .Pos_Y(Pos_Y),
    .play(play), .flip_x(flip_x), .hit(hit),
    .is_sprite(sc_is), .frame_idx(sc_fi), .blinking(sc_bl), .done(sc_dn));
`endif

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One frame_clk rising edge, then let the pixel register see the result.
  task automatic ftick();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Pos_X = 10'd0; Pos_Y = 10'd0; DrawX = 10'd0; DrawY = 10'd0;
    step(); step();
    total++; if (loop_is !== 1'b0) begin bad++; $display("FAIL reset_is_sprite got=%b exp=0", loop_is); end
    total++; if (loop_fi !== 2'd0) begin bad++; $display("FAIL reset_frame_idx got=%0d exp=0", loop_fi); end
    total++; if (loop_bl !== 1'b0) begin bad++; $display("FAIL reset_blinking got=%b exp=0", loop_bl); end
    total++; if (one_dn !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", one_dn); end
    Reset = 1'b0;
    step();
    total++; if (loop_is !== 1'b1) begin bad++; $display("FAIL post_reset_pixel got=%b exp=1", loop_is); end
  endtask

  task automatic test_pixel();
    Pos_X = 10'd100; Pos_Y = 10'd50; DrawY = 10'd53; flip_x = 1'b0;
    DrawX = 10'd100;
    step();
    total++; if (pix_is !== 1'b1) begin bad++; $display("FAIL pix_100_53 got=%b exp=1", pix_is); end
    // Output must not change until the next Clk.
    DrawX = 10'd115;
    #2;
    total++; if (pix_is !== 1'b1) begin bad++; $display("FAIL pix_latency got=%b exp=1", pix_is); end
    step();
    total++; if (pix_is !== 1'b0) begin bad++; $display("FAIL pix_115_53 got=%b exp=0", pix_is); end
    flip_x = 1'b1;
    step();
    total++; if (pix_is !== 1'b1) begin bad++; $display("FAIL flip_115_53 got=%b exp=1", pix_is); end
    DrawX = 10'd100;
    step();
    total++; if (pix_is !== 1'b0) begin bad++; $display("FAIL flip_100_53 got=%b exp=0", pix_is); end
    DrawX = 10'd100; DrawY = 10'd52; flip_x = 1'b0;
    step();
    total++; if (pix_is !== 1'b0) begin bad++; $display("FAIL pix_100_52 got=%b exp=0", pix_is); end
    flip_x = 1'b0;
  endtask

  task automatic test_bounds();
    Pos_X = 10'd1020; Pos_Y = 10'd0; DrawY = 10'd0; flip_x = 1'b0;
    DrawX = 10'd1023;
    step();
    total++; if (loop_is !== 1'b1) begin bad++; $display("FAIL bound_1023 got=%b exp=1", loop_is); end
    DrawX = 10'd1020;
    step();
    total++; if (loop_is !== 1'b1) begin bad++; $display("FAIL bound_1020 got=%b exp=1", loop_is); end
    for (int x = 0; x < 12; x++) begin
      DrawX = 10'(x);
      step();
      total++; if (loop_is !== 1'b0) begin bad++; $display("FAIL bound_wrap x=%0d got=%b exp=0", x, loop_is); end
    end
    DrawX = 10'd1019;
    step();
    total++; if (loop_is !== 1'b0) begin bad++; $display("FAIL bound_1019 got=%b exp=0", loop_is); end
  endtask

  task automatic test_loop();
    logic [1:0] exp_fi [0:7];
    exp_fi = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    play = 1'b1;
    step();
    total++; if (loop_fi !== 2'd0) begin bad++; $display("FAIL loop_start got=%0d exp=0", loop_fi); end
    for (int k = 0; k < 8; k++) begin
      ftick();
      total++; if (loop_fi !== exp_fi[k]) begin bad++; $display("FAIL loop_tick%0d got=%0d exp=%0d", k + 1, loop_fi, exp_fi[k]); end
    end
    ftick(); ftick(); ftick();
    total++; if (loop_fi !== 2'd1) begin bad++; $display("FAIL loop_midhold got=%0d exp=1", loop_fi); end
    // play=0 together with a tick: the stop must win.
    play = 1'b0; frame_clk = 1'b1;
    step();
    total++; if (loop_fi !== 2'd0) begin bad++; $display("FAIL loop_stop got=%0d exp=0", loop_fi); end
    frame_clk = 1'b0;
    step();
    ftick();
    total++; if (loop_fi !== 2'd0) begin bad++; $display("FAIL loop_idle_hold got=%0d exp=0", loop_fi); end
  endtask

  task automatic test_oneshot();
    logic [1:0] exp_fi [0:2];
    logic       exp_dn [0:2];
    exp_fi = '{2'd1, 2'd2, 2'd2};
    exp_dn = '{1'b0, 1'b0, 1'b1};
    total++; if (one_dn !== 1'b0) begin bad++; $display("FAIL one_idle_done got=%b exp=0", one_dn); end
    play = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      ftick();
      total++; if (one_fi !== exp_fi[k]) begin bad++; $display("FAIL one_tick%0d_fi got=%0d exp=%0d", k + 1, one_fi, exp_fi[k]); end
      total++; if (one_dn !== exp_dn[k]) begin bad++; $display("FAIL one_tick%0d_done got=%b exp=%b", k + 1, one_dn, exp_dn[k]); end
    end
    ftick(); ftick();
    total++; if (one_fi !== 2'd2) begin bad++; $display("FAIL one_hold_fi got=%0d exp=2", one_fi); end
    total++; if (one_dn !== 1'b1) begin bad++; $display("FAIL one_hold_done got=%b exp=1", one_dn); end
    play = 1'b0;
    step();
    total++; if (one_fi !== 2'd0) begin bad++; $display("FAIL one_stop_fi got=%0d exp=0", one_fi); end
    total++; if (one_dn !== 1'b0) begin bad++; $display("FAIL one_stop_done got=%b exp=0", one_dn); end
  endtask

  // Visibility of an inside pixel indexed by blink counter value 0..8.
  task automatic blink_run(input int start, input int n);
    logic [8:0] vis_tab;
    int         cnt;
    vis_tab = 9'b100110011;
    for (int k = 1; k <= n; k++) begin
      ftick();
      cnt = start - k;
      total++; if (bl_is !== vis_tab[cnt]) begin bad++; $display("FAIL blink_vis cnt=%0d got=%b exp=%b", cnt, bl_is, vis_tab[cnt]); end
      total++; if (bl_bl !== (cnt != 0)) begin bad++; $display("FAIL blink_flag cnt=%0d got=%b exp=%b", cnt, bl_bl, (cnt != 0)); end
    end
  endtask

  task automatic test_blink();
    play = 1'b0; flip_x = 1'b0;
    Pos_X = 10'd0; Pos_Y = 10'd0; DrawX = 10'd5; DrawY = 10'd5;
    step();
    total++; if (bl_is !== 1'b1) begin bad++; $display("FAIL blink_pre_vis got=%b exp=1", bl_is); end
    hit = 1'b1;
    step();
    hit = 1'b0;
    total++; if (bl_bl !== 1'b1) begin bad++; $display("FAIL blink_start got=%b exp=1", bl_bl); end
    step();
    total++; if (bl_is !== 1'b1) begin bad++; $display("FAIL blink_cnt8_vis got=%b exp=1", bl_is); end
    blink_run(8, 5);
    // Counter at 3: reload to 8, then it must last 8 more ticks.
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
    total++; if (bl_is !== 1'b1) begin bad++; $display("FAIL blink_reload_vis got=%b exp=1", bl_is); end
    blink_run(8, 8);
    // hit coincident with a tick loads 8 (visible), not 7 (blanked).
    hit = 1'b1; frame_clk = 1'b1;
    step();
    hit = 1'b0; frame_clk = 1'b0;
    step();
    total++; if (bl_is !== 1'b1) begin bad++; $display("FAIL blink_hit_prio got=%b exp=1", bl_is); end
    blink_run(8, 1);
  endtask

  task automatic test_midreset();
    play = 1'b1;
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
    ftick(); ftick(); ftick();
    total++; if (loop_fi !== 2'd1) begin bad++; $display("FAIL mid_pre_fi got=%0d exp=1", loop_fi); end
    Reset = 1'b1;
    step();
    total++; if (loop_fi !== 2'd0) begin bad++; $display("FAIL mid_reset_fi got=%0d exp=0", loop_fi); end
    total++; if (bl_bl !== 1'b0) begin bad++; $display("FAIL mid_reset_blink got=%b exp=0", bl_bl); end
    total++; if (bl_is !== 1'b0) begin bad++; $display("FAIL mid_reset_is got=%b exp=0", bl_is); end
    Reset = 1'b0;
    play = 1'b0;
    step();
  endtask

`ifdef SPRITE_SCALE2_EN
  task automatic test_scale2();
    Pos_X = 10'd0; Pos_Y = 10'd0; flip_x = 1'b0; play = 1'b0;
    for (int y = 2; y < 4; y++) begin
      for (int x = 2; x < 4; x++) begin
        DrawX = 10'(x); DrawY = 10'(y);
        step();
        total++; if (sc_is !== 1'b1) begin bad++; $display("FAIL scale_%0d_%0d got=%b exp=1", x, y, sc_is); end
      end
    end
    DrawX = 10'd4; DrawY = 10'd2;
    step();
    total++; if (sc_is !== 1'b0) begin bad++; $display("FAIL scale_4_2 got=%b exp=0", sc_is); end
    DrawX = 10'd31; DrawY = 10'd31;
    step();
    total++; if (sc_is !== 1'b0) begin bad++; $display("FAIL scale_31_31 got=%b exp=0", sc_is); end
    total++; if (loop_is !== 1'b1) begin bad++; $display("FAIL scale_footprint got=%b exp=1", loop_is); end
    DrawX = 10'd32; DrawY = 10'd2;
    step();
    total++; if (loop_is !== 1'b0) begin bad++; $display("FAIL scale_outside got=%b exp=0", loop_is); end
  endtask
`endif

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; play = 1'b0; flip_x = 1'b0; hit = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; Pos_X = 10'd0; Pos_Y = 10'd0;
    test_reset();
`ifndef SPRITE_SCALE2_EN
    test_pixel();
`endif
    test_bounds();
    test_loop();
    test_oneshot();
    test_blink();
    test_midreset();
`ifdef SPRITE_SCALE2_EN
    test_scale2();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
